monster_shot_controller: RTL
============================

# monster_shot_controller

Manages the pool of active monster shots: accepts fire requests from the monster formation, allocates shot slots, advances every live shot once per frame, and retires shots that leave the screen or hit something. Each pixel it reports whether that pixel lies inside a live shot, plus the in-shot offset, to drive `monster_shot_bitmap` (2×4 px). It sits between the monster formation logic, the VGA pixel counters and the collision detector.

## Interface
Parameters:
- `MAX_SHOTS`, 4: number of shot slots (1–8).
- `SHOT_W`, 2: shot width in px; must match the bitmap.
- `SHOT_H`, 4: shot height in px; must match the bitmap.
- `SPEED_Y`, 2: px moved down per frame.
- `COOLDOWN_FRAMES`, 30: minimum frames between accepted fires.
- `SCREEN_BOTTOM`, 479: last visible row.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `pixelX`, `pixelY` in 11 each: current VGA pixel.
- `fireReq` in 1: formation requests a shot.
- `fireX`, `fireY` in 11 each: spawn top-left, valid with `fireReq`.
- `collisionShot` in 1: collision detector reports that a monster-shot pixel hit the player or a shield.
- `clearAll` in 1: level restart; kills all shots.
- `fireAck` out 1: one-cycle pulse, request accepted.
- `insideRectangle` out 1: current pixel is inside a live shot.
- `offsetX` out 11: pixel offset inside the shot, range 0..SHOT_W-1.
- `offsetY` out 11: pixel offset inside the shot, range 0..SHOT_H-1.
- `activeCount` out 4: number of live slots.

## Operation
- Each slot holds `valid`, `x[10:0]` and `y[10:0]`.
- Fire:
  - Accepted when `fireReq`, `cooldown==0`, at least one free slot, and `!clearAll`.
  - The lowest-index free slot is loaded with `fireX`/`fireY` and marked valid.
  - `cooldown` is loaded with `COOLDOWN_FRAMES`; `fireAck` pulses for one cycle.
  - A denied request is dropped with no ack. The requester may re-assert.
- Cooldown: decremented on each `startOfFrame` while nonzero, saturating at 0.
- Motion: on `startOfFrame`, every valid slot does `y <= y + SPEED_Y`, computed 12-bit to avoid wrap.
  - A slot is retired when the new `y > SCREEN_BOTTOM`.
  - A slot allocated in the same cycle is not moved.
- Hit test, per pixel: a slot hits when `x <= pixelX < x+SHOT_W` and `y <= pixelY < y+SHOT_H`.
  - With overlapping slots, the lowest index wins.
  - Offsets are `pixelX-x` and `pixelY-y`.
- Collision retire:
  - The winning slot index and a hit flag go through a 2-stage pipeline, matching controller register + bitmap register.
  - When `collisionShot=1` and stage-2 hit flag=1, the stage-2 slot is invalidated.
  - `collisionShot` with stage-2 hit flag=0 is ignored.
- Priorities:
  - `clearAll` overrides everything: all slots invalid, pipeline cleared, cooldown=0, no ack.
  - Collision retire beats a motion update of the same slot.
  - Fire may reuse a slot freed by collision only from the next cycle onward.

## Timing
- Reset: all slots invalid, cooldown 0, pipeline cleared. All outputs 0.
- `insideRectangle`, `offsetX`, `offsetY`: registered, 1 cycle after `pixelX`/`pixelY`.
- `fireAck`: registered, high the cycle after the accepting `fireReq` cycle. The slot is visible to the hit test from that same cycle.
- `activeCount`: registered, reflects slot state after the previous cycle's updates.
- `collisionShot` is sampled as aligned with the pixel presented 2 cycles earlier.
- Reset asserted mid-frame clears everything immediately (asynchronously). Operation resumes on the first clock after deassertion.

## Structure
- `monster_shot_pkg` holds `shot_slot_t` (struct of `valid`, `x`, `y`), the `SCREEN_BOTTOM` default and the slot-index width function.
- Sub-module `monster_shot_slot`, one instance per slot. It holds slot state and does load, move, kill and hit compare, outputting a hit flag and offsets.
- The top level holds:
  - free-slot priority encoder
  - hit priority mux
  - cooldown counter
  - collision pipeline

## Test plan
- Single fire: `fireReq` at (100,50) with pool empty → `fireAck` next cycle, slot0 valid, `activeCount=1`. Pixel (101,53) → `insideRectangle=1`, offset (1,3), one cycle later.
- Cooldown: second `fireReq` 5 frames after the first → no ack. After 30 `startOfFrame` pulses → ack.
- Pool full (with `COOLDOWN_FRAMES=0`): 4 fires accepted, 5th denied, `activeCount=4`.
- Motion and exit:
  - Shot at y=474, `startOfFrame` → y=476, still live.
  - Next `startOfFrame` → y=478, still live.
  - Next `startOfFrame` → y=480, retired, `activeCount` decrements.
- Collision: pixel inside slot1, then `collisionShot=1` 2 cycles later → slot1 invalid, other slots unaffected. `collisionShot` with no shot pixel → no change.
- Simultaneous events:
  - `clearAll` together with `fireReq` → no ack, all invalid.
  - Collision together with `startOfFrame` on the same slot → slot retired.
  - Reset mid-frame → all outputs 0.

Source files
------------

// File: rtl/monster_shot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : monster_shot_pkg
// Purpose  : Shared types, defaults and helpers for the monster shot pool.
// Revision : 1.0 - initial release
// ============================================================================
package monster_shot_pkg;

    localparam int COORD_W               = 11;
    localparam int SCREEN_BOTTOM_DEFAULT = 479;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } shot_slot_t;

    // Width needed to index n items; never below one bit.
    function automatic int slot_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/monster_shot_slot.sv
`default_nettype none
// ============================================================================
// Module   : monster_shot_slot
// Purpose  : One shot slot: load, per-frame move, kill and pixel hit compare.
// Revision : 1.0 - initial release
// ============================================================================
module monster_shot_slot
    import monster_shot_pkg::*;
#(
    parameter int SHOT_W        = 2,
    parameter int SHOT_H        = 4,
    parameter int SPEED_Y       = 2,
    parameter int SCREEN_BOTTOM = SCREEN_BOTTOM_DEFAULT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        load_i,
    input  logic [10:0] loadX_i,
    input  logic [10:0] loadY_i,
    input  logic        move_i,
    input  logic        kill_i,
    input  logic [10:0] pixelX_i,
    input  logic [10:0] pixelY_i,
    output logic        valid_o,
    output logic        validNext_o,
    output logic        hit_o,
    output logic [10:0] offsetX_o,
    output logic [10:0] offsetY_o
);

    shot_slot_t  slot_q, slot_d;
    logic [11:0] w_yMoved;
    logic [11:0] w_dx;
    logic [11:0] w_dy;

    // Kill beats load beats move; a freshly loaded shot does not move this cycle.
    always_comb begin
        slot_d   = slot_q;
        w_yMoved = {1'b0, slot_q.y} + 12'(SPEED_Y);
        if (kill_i) begin
            slot_d.valid = 1'b0;
        end else if (load_i) begin
            slot_d.valid = 1'b1;
            slot_d.x     = loadX_i;
            slot_d.y     = loadY_i;
        end else if (move_i && slot_q.valid) begin
            if (w_yMoved > 12'(SCREEN_BOTTOM)) begin
                slot_d.valid = 1'b0;
            end else begin
                slot_d.y = w_yMoved[10:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // A pixel left of / above the shot wraps to a huge difference and fails the range test.
    assign w_dx = {1'b0, pixelX_i} - {1'b0, slot_q.x};
    assign w_dy = {1'b0, pixelY_i} - {1'b0, slot_q.y};

    assign hit_o       = slot_q.valid && (w_dx < 12'(SHOT_W)) && (w_dy < 12'(SHOT_H));
    assign offsetX_o   = w_dx[10:0];
    assign offsetY_o   = w_dy[10:0];
    assign valid_o     = slot_q.valid;
    assign validNext_o = slot_d.valid;

endmodule
`default_nettype wire

// File: rtl/monster_shot_controller.sv
`default_nettype none
// ============================================================================
// Module   : monster_shot_controller
// Purpose  : Monster shot pool: fire allocation, cooldown, motion, hit test
//            and collision retire.
// Revision : 1.0 - initial release
// ============================================================================
module monster_shot_controller
    import monster_shot_pkg::*;
#(
    parameter int MAX_SHOTS       = 4,
    parameter int SHOT_W          = 2,
    parameter int SHOT_H          = 4,
    parameter int SPEED_Y         = 2,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int SCREEN_BOTTOM   = SCREEN_BOTTOM_DEFAULT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        fireReq,
    input  logic [10:0] fireX,
    input  logic [10:0] fireY,
    input  logic        collisionShot,
    input  logic        clearAll,
    output logic        fireAck,
    output logic        insideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [3:0]  activeCount
);

    localparam int IDX_W = slot_idx_w(MAX_SHOTS);
    localparam int CD_W  = slot_idx_w(COOLDOWN_FRAMES + 1);

    logic [MAX_SHOTS-1:0] w_valid, w_validNext, w_hit, w_load, w_kill;
    logic [10:0]          w_offX [MAX_SHOTS];
    logic [10:0]          w_offY [MAX_SHOTS];
    logic                 w_freeFound, w_hitAny, w_fire;
    logic [IDX_W-1:0]     w_freeIdx, w_hitIdx;
    logic [10:0]          w_selOffX, w_selOffY;
    logic [3:0]           w_count;

    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic             fireAck_q, inside_q, hit2_q;
    logic [10:0]      offX_q, offY_q;
    logic [IDX_W-1:0] idx1_q, idx2_q;
    logic [3:0]       count_q;

    assign w_fire = fireReq && (cooldown_q == '0) && w_freeFound && !clearAll;

    generate
        for (genvar i = 0; i < MAX_SHOTS; i++) begin : g_slot
            assign w_load[i] = w_fire && (w_freeIdx == IDX_W'(i));
            // Only a still-live slot can be retired by a delayed collision report.
            assign w_kill[i] = clearAll ||
                               (collisionShot && hit2_q && (idx2_q == IDX_W'(i)) && w_valid[i]);

            monster_shot_slot #(
                .SHOT_W        (SHOT_W),
                .SHOT_H        (SHOT_H),
                .SPEED_Y       (SPEED_Y),
                .SCREEN_BOTTOM (SCREEN_BOTTOM)
            ) u_slot (
                .clk         (clk),
                .resetN      (resetN),
                .load_i      (w_load[i]),
                .loadX_i     (fireX),
                .loadY_i     (fireY),
                .move_i      (startOfFrame),
                .kill_i      (w_kill[i]),
                .pixelX_i    (pixelX),
                .pixelY_i    (pixelY),
                .valid_o     (w_valid[i]),
                .validNext_o (w_validNext[i]),
                .hit_o       (w_hit[i]),
                .offsetX_o   (w_offX[i]),
                .offsetY_o   (w_offY[i])
            );
        end
    endgenerate

    // Descending scans so the lowest index ends up selected.
    always_comb begin
        w_freeFound = 1'b0;
        w_freeIdx   = '0;
        w_hitAny    = 1'b0;
        w_hitIdx    = '0;
        w_selOffX   = '0;
        w_selOffY   = '0;
        w_count     = '0;
        for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_freeFound = 1'b1;
                w_freeIdx   = IDX_W'(i);
            end
            if (w_hit[i]) begin
                w_hitAny  = 1'b1;
                w_hitIdx  = IDX_W'(i);
                w_selOffX = w_offX[i];
                w_selOffY = w_offY[i];
            end
            w_count = w_count + 4'(w_validNext[i]);
        end
    end

    always_comb begin
        cooldown_d = cooldown_q;
        if (clearAll) begin
            cooldown_d = '0;
        end else if (w_fire) begin
            cooldown_d = CD_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown_q <= '0;
            fireAck_q  <= 1'b0;
            count_q    <= '0;
            inside_q   <= 1'b0;
            offX_q     <= '0;
            offY_q     <= '0;
            idx1_q     <= '0;
            hit2_q     <= 1'b0;
            idx2_q     <= '0;
        end else begin
            cooldown_q <= cooldown_d;
            fireAck_q  <= w_fire;
            count_q    <= w_count;
            if (clearAll) begin
                inside_q <= 1'b0;
                offX_q   <= '0;
                offY_q   <= '0;
                idx1_q   <= '0;
                hit2_q   <= 1'b0;
                idx2_q   <= '0;
            end else begin
                inside_q <= w_hitAny;
                offX_q   <= w_selOffX;
                offY_q   <= w_selOffY;
                idx1_q   <= w_hitIdx;
                hit2_q   <= inside_q;
                idx2_q   <= idx1_q;
            end
        end
    end

    assign fireAck         = fireAck_q;
    assign insideRectangle = inside_q;
    assign offsetX         = offX_q;
    assign offsetY         = offY_q;
    assign activeCount     = count_q;

endmodule
`default_nettype wire
